// File: rtl/wom_write_arbiter.sv
// rtl/wom_write_arbiter.sv - two-requester arbiter for the single write port of the 1K x 16 write-only memory
module wom_write_arbiter #(
  parameter int AW        = 10,
  parameter int DW        = 16,
  parameter int MAX_BURST = 4,
  parameter int PRIORITY  = 0
) (
  input  logic          CLK,
  input  logic          HRESETn,
  input  logic          a_valid,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_data,
  output logic          a_ready,
  input  logic          b_valid,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_data,
  output logic          b_ready,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          wr_we,
  output logic [1:0]    owner
);

  localparam int            CW       = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);
  localparam logic          LSP_A    = 1'b0;
  localparam logic          LSP_B    = 1'b1;

  // Encoding doubles as the owner code: 00 idle, 01 A, 10 B.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWN_A = 2'b01,
    OWN_B = 2'b10
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          lsp, lsp_nx;
  logic          accept_a, accept_b;
  logic          at_limit;

  assign a_ready  = (state == OWN_A);
  assign b_ready  = (state == OWN_B);
  assign owner    = state;
  assign accept_a = a_valid & a_ready;
  assign accept_b = b_valid & b_ready;
  // True when the accept happening now is the owner's MAX_BURST-th in a row.
  assign at_limit = (cnt == CNT_LAST);

  // Ownership state, burst counter and last-served pointer.
  always_ff @(posedge CLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= IDLE;
      cnt   <= '0;
      lsp   <= LSP_B;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      lsp   <= lsp_nx;
    end
  end

  // Next owner: burst limit hands over with no bubble; a dropped valid releases the port.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    lsp_nx   = lsp;
    case (state)
      IDLE: begin
        if (a_valid && (!b_valid || (PRIORITY != 0) || (lsp == LSP_B))) begin
          state_nx = OWN_A;
        end else if (b_valid) begin
          state_nx = OWN_B;
        end
      end
      OWN_A: begin
        if (a_valid) begin
          if (b_valid && at_limit) begin
            state_nx = OWN_B;
            cnt_nx   = '0;
            lsp_nx   = LSP_A;
          end else if (!at_limit) begin
            cnt_nx = cnt + 1'b1;
          end
        end else begin
          state_nx = b_valid ? OWN_B : IDLE;
          cnt_nx   = '0;
          lsp_nx   = LSP_A;
        end
      end
      OWN_B: begin
        // With fixed priority, a waiting A takes the port back after every B accept.
        if (b_valid) begin
          if (a_valid && (at_limit || (PRIORITY != 0))) begin
            state_nx = OWN_A;
            cnt_nx   = '0;
            lsp_nx   = LSP_B;
          end else if (!at_limit) begin
            cnt_nx = cnt + 1'b1;
          end
        end else begin
          state_nx = a_valid ? OWN_A : IDLE;
          cnt_nx   = '0;
          lsp_nx   = LSP_B;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Registered memory write port; address and data hold between writes.
  always_ff @(posedge CLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_we   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else if (accept_a) begin
      wr_we   <= 1'b1;
      wr_addr <= a_addr;
      wr_data <= a_data;
    end else if (accept_b) begin
      wr_we   <= 1'b1;
      wr_addr <= b_addr;
      wr_data <= b_data;
    end else begin
      wr_we   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wom_write_arbiter.sv
// tb/tb_wom_write_arbiter.sv - self-checking bench for wom_write_arbiter
module tb_wom_write_arbiter;

  localparam int N  = 3;
  localparam int AW = 10;
  localparam int DW = 16;
  localparam int HL = 512;

  logic CLK = 1'b0;
  logic HRESETn;
  always #5 CLK = ~CLK;

  logic          a_valid [N];
  logic [AW-1:0] a_addr  [N];
  logic [DW-1:0] a_data  [N];
  logic          a_ready [N];
  logic          b_valid [N];
  logic [AW-1:0] b_addr  [N];
  logic [DW-1:0] b_data  [N];
  logic          b_ready [N];
  logic [AW-1:0] wr_addr [N];
  logic [DW-1:0] wr_data [N];
  logic          wr_we   [N];
  logic [1:0]    owner   [N];

  // u0: round-robin, burst 4; u1: fixed priority, burst 2; u2: round-robin, burst 1
  wom_write_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(4), .PRIORITY(0)) u0 (
    .CLK(CLK), .HRESETn(HRESETn),
    .a_valid(a_valid[0]), .a_addr(a_addr[0]), .a_data(a_data[0]), .a_ready(a_ready[0]),
    .b_valid(b_valid[0]), .b_addr(b_addr[0]), .b_data(b_data[0]), .b_ready(b_ready[0]),
    .wr_addr(wr_addr[0]), .wr_data(wr_data[0]), .wr_we(wr_we[0]), .owner(owner[0]));
  wom_write_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(2), .PRIORITY(1)) u1 (
    .CLK(CLK), .HRESETn(HRESETn),
    .a_valid(a_valid[1]), .a_addr(a_addr[1]), .a_data(a_data[1]), .a_ready(a_ready[1]),
    .b_valid(b_valid[1]), .b_addr(b_addr[1]), .b_data(b_data[1]), .b_ready(b_ready[1]),
    .wr_addr(wr_addr[1]), .wr_data(wr_data[1]), .wr_we(wr_we[1]), .owner(owner[1]));
  wom_write_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(1), .PRIORITY(0)) u2 (
    .CLK(CLK), .HRESETn(HRESETn),
    .a_valid(a_valid[2]), .a_addr(a_addr[2]), .a_data(a_data[2]), .a_ready(a_ready[2]),
    .b_valid(b_valid[2]), .b_addr(b_addr[2]), .b_data(b_data[2]), .b_ready(b_ready[2]),
    .wr_addr(wr_addr[2]), .wr_data(wr_data[2]), .wr_we(wr_we[2]), .owner(owner[2]));

  // requester model: word k of a stream is {base + step*k, dbase + k}; A data has bit15=0, B bit15=1
  int            a_tot [N], a_sent [N], a_rate [N], a_step [N];
  int            b_tot [N], b_sent [N], b_rate [N], b_step [N];
  logic [AW-1:0] a_base [N], b_base [N];
  logic [DW-1:0] a_dbase [N], b_dbase [N];
  int            mb_of [N];

  // per-cycle history: index c describes rising edge number c after the last reset
  logic [AW-1:0] w_addr [N][HL];
  logic [DW-1:0] w_data [N][HL];
  int            wn [N];
  bit            we_h [N][HL];
  bit            acc_h [N][HL];
  bit            av_h [N][HL];
  bit            bv_h [N][HL];
  logic [1:0]    own_h [N][HL];
  int            cn;

  int checks;
  int errors;

  task automatic drive(int i, bit aacc, bit bacc);
    if (!a_valid[i] || aacc)
      a_valid[i] = (a_sent[i] < a_tot[i]) && (int'($urandom_range(99)) < a_rate[i]);
    a_addr[i] = AW'(int'(a_base[i]) + a_step[i] * a_sent[i]);
    a_data[i] = DW'(int'(a_dbase[i]) + a_sent[i]);
    if (!b_valid[i] || bacc)
      b_valid[i] = (b_sent[i] < b_tot[i]) && (int'($urandom_range(99)) < b_rate[i]);
    b_addr[i] = AW'(int'(b_base[i]) + b_step[i] * b_sent[i]);
    b_data[i] = DW'(int'(b_dbase[i]) + b_sent[i]);
  endtask

  task automatic setup_a(int i, int tot, logic [AW-1:0] base, int step, logic [DW-1:0] dbase, int rate);
    a_tot[i] = tot; a_sent[i] = 0; a_base[i] = base; a_step[i] = step; a_dbase[i] = dbase; a_rate[i] = rate;
    drive(i, 1'b0, 1'b0);
  endtask

  task automatic setup_b(int i, int tot, logic [AW-1:0] base, int step, logic [DW-1:0] dbase, int rate);
    b_tot[i] = tot; b_sent[i] = 0; b_base[i] = base; b_step[i] = step; b_dbase[i] = dbase; b_rate[i] = rate;
    drive(i, 1'b0, 1'b0);
  endtask

  task automatic clear_all();
    for (int i = 0; i < N; i++) begin
      a_valid[i] = 1'b0; a_addr[i] = '0; a_data[i] = '0; a_tot[i] = 0; a_sent[i] = 0;
      b_valid[i] = 1'b0; b_addr[i] = '0; b_data[i] = '0; b_tot[i] = 0; b_sent[i] = 0;
      a_rate[i] = 100; b_rate[i] = 100; a_step[i] = 1; b_step[i] = 1;
      a_base[i] = '0; b_base[i] = '0; a_dbase[i] = '0; b_dbase[i] = 16'h8000;
      wn[i] = 0;
      for (int c = 0; c < HL; c++) begin
        we_h[i][c] = 1'b0; acc_h[i][c] = 1'b0; av_h[i][c] = 1'b0; bv_h[i][c] = 1'b0; own_h[i][c] = 2'b00;
      end
    end
    cn = 0;
  endtask

  task automatic do_reset();
    HRESETn = 1'b0;
    clear_all();
    repeat (2) @(posedge CLK);
    #1;
    HRESETn = 1'b1;
  endtask

  // one clock: sample handshakes at the falling edge, advance requesters after the rising edge
  task automatic cycle();
    bit ha [N];
    bit hb [N];
    @(negedge CLK);
    for (int i = 0; i < N; i++) begin
      ha[i] = a_valid[i] && a_ready[i];
      hb[i] = b_valid[i] && b_ready[i];
      if (cn < HL - 1) begin
        av_h[i][cn+1] = a_valid[i]; bv_h[i][cn+1] = b_valid[i]; acc_h[i][cn+1] = ha[i] | hb[i];
      end
    end
    @(posedge CLK);
    #1;
    if (cn < HL - 1) cn++;
    for (int i = 0; i < N; i++) begin
      if (ha[i]) a_sent[i]++;
      if (hb[i]) b_sent[i]++;
      drive(i, ha[i], hb[i]);
      we_h[i][cn] = wr_we[i];
      own_h[i][cn] = owner[i];
      if (wr_we[i] && wn[i] < HL) begin
        w_addr[i][wn[i]] = wr_addr[i];
        w_data[i][wn[i]] = wr_data[i];
        wn[i]++;
      end
    end
  endtask

  // reference: per-source write streams must equal each requester's word sequence, in order
  function automatic int word_errs(int i);
    int ka, kb, bad;
    ka = 0; kb = 0; bad = 0;
    for (int k = 0; k < wn[i]; k++) begin
      if (!w_data[i][k][15]) begin
        if (w_addr[i][k] !== AW'(int'(a_base[i]) + a_step[i] * ka) || w_data[i][k] !== DW'(int'(a_dbase[i]) + ka)) bad++;
        ka++;
      end else begin
        if (w_addr[i][k] !== AW'(int'(b_base[i]) + b_step[i] * kb) || w_data[i][k] !== DW'(int'(b_dbase[i]) + kb)) bad++;
        kb++;
      end
    end
    return bad;
  endfunction

  function automatic string src_str(int i, int n);
    string s;
    s = "";
    for (int k = 0; k < n && k < wn[i]; k++) s = {s, (w_data[i][k][15] ? "B" : "A")};
    return s;
  endfunction

  // longest run of writes by one side while the other side was waiting
  function automatic int max_wait_run(int i);
    int ra, rb, mx, k;
    ra = 0; rb = 0; mx = 0; k = 0;
    for (int c = 1; c <= cn; c++) begin
      if (we_h[i][c] && k < wn[i]) begin
        if (!w_data[i][k][15]) begin
          rb = 0; ra = bv_h[i][c] ? ra + 1 : 0;
        end else begin
          ra = 0; rb = av_h[i][c] ? rb + 1 : 0;
        end
        if (ra > mx) mx = ra;
        if (rb > mx) mx = rb;
        k++;
      end
    end
    return mx;
  endfunction

  task automatic test_reset();
    HRESETn = 1'b0;
    clear_all();
    #12;
    for (int i = 0; i < N; i++) begin
      checks++;
      if ({wr_we[i], a_ready[i], b_ready[i], owner[i], wr_addr[i], wr_data[i]} !== '0) begin
        errors++;
        $display("FAIL reset_state[%0d]: we=%b ar=%b br=%b own=%b addr=%h data=%h, required all zero",
                 i, wr_we[i], a_ready[i], b_ready[i], owner[i], wr_addr[i], wr_data[i]);
      end
    end
    do_reset();
    setup_a(0, 20, 10'h000, 1, 16'h0A00, 100);
    setup_b(0, 20, 10'h200, 1, 16'h8B00, 100);
    repeat (5) cycle();
    checks++;
    if (wr_we[0] !== 1'b1 || owner[0] !== 2'b10) begin
      errors++;
      $display("FAIL reset_prestream: we=%b owner=%b, required we=1 owner=10", wr_we[0], owner[0]);
    end
    #2;
    HRESETn = 1'b0;
    #1;
    checks++;
    if ({wr_we[0], a_ready[0], b_ready[0], owner[0]} !== 5'b0) begin
      errors++;
      $display("FAIL reset_async: we=%b ar=%b br=%b owner=%b, required all zero", wr_we[0], a_ready[0], b_ready[0], owner[0]);
    end
    checks++;
    if (wr_addr[0] !== '0 || wr_data[0] !== '0) begin
      errors++;
      $display("FAIL reset_async_bus: addr=%h data=%h, required 0/0", wr_addr[0], wr_data[0]);
    end
    @(posedge CLK);
    #1;
    checks++;
    if ({wr_we[0], owner[0], wr_addr[0], wr_data[0]} !== '0) begin
      errors++;
      $display("FAIL reset_held: we=%b owner=%b addr=%h data=%h, required all zero", wr_we[0], owner[0], wr_addr[0], wr_data[0]);
    end
    do_reset();
    setup_a(0, 4, 10'h010, 1, 16'h0C00, 100);
    setup_b(0, 4, 10'h110, 1, 16'h8C00, 100);
    cycle();
    checks++;
    if (owner[0] !== 2'b01) begin
      errors++;
      $display("FAIL reset_restart_lsp: owner=%b, required 01", owner[0]);
    end
  endtask

  task automatic test_a_only();
    do_reset();
    setup_a(0, 1, 10'h155, 1, 16'hBEEF, 100);
    checks++;
    if (a_ready[0] !== 1'b0) begin
      errors++; $display("FAIL a_only_ready0: a_ready=%b, required 0", a_ready[0]);
    end
    cycle();
    checks++;
    if (a_ready[0] !== 1'b1 || wr_we[0] !== 1'b0) begin
      errors++; $display("FAIL a_only_ready1: a_ready=%b we=%b, required 1/0", a_ready[0], wr_we[0]);
    end
    cycle();
    checks++;
    if (wr_we[0] !== 1'b1 || wr_addr[0] !== 10'h155 || wr_data[0] !== 16'hBEEF) begin
      errors++;
      $display("FAIL a_only_write: we=%b addr=%h data=%h, required 1/155/beef", wr_we[0], wr_addr[0], wr_data[0]);
    end
    cycle();
    checks++;
    if (wr_we[0] !== 1'b0 || owner[0] !== 2'b00 || wr_addr[0] !== 10'h155 || wr_data[0] !== 16'hBEEF) begin
      errors++;
      $display("FAIL a_only_after: we=%b owner=%b addr=%h data=%h, required 0/00/155/beef",
               wr_we[0], owner[0], wr_addr[0], wr_data[0]);
    end
  endtask

  task automatic test_round_robin_burst();
    int gaps;
    do_reset();
    setup_a(0, 20, 10'h000, 1, 16'h0A00, 100);
    setup_b(0, 20, 10'h200, 1, 16'h8B00, 100);
    while (wn[0] < 12 && cn < 40) cycle();
    checks++;
    if (wn[0] < 12) begin
      errors++; $display("FAIL rr_timeout: writes=%0d, required 12", wn[0]);
    end
    checks++;
    if (src_str(0, 12) != "AAAABBBBAAAA") begin
      errors++; $display("FAIL rr_order: got %s, required AAAABBBBAAAA", src_str(0, 12));
    end
    gaps = 0;
    for (int c = 2; c <= 13; c++) if (!we_h[0][c]) gaps++;
    checks++;
    if (we_h[0][1] !== 1'b0 || gaps != 0) begin
      errors++; $display("FAIL rr_throughput: first_we=%b gaps=%0d, required 0/0", we_h[0][1], gaps);
    end
    checks++;
    if (word_errs(0) != 0) begin
      errors++; $display("FAIL rr_words: bad=%0d, required 0", word_errs(0));
    end
  endtask

  task automatic test_tie();
    do_reset();
    setup_a(0, 1, 10'h020, 1, 16'h0100, 100);
    setup_b(0, 1, 10'h120, 1, 16'h8100, 100);
    cycle();
    checks++;
    if (owner[0] !== 2'b01) begin
      errors++; $display("FAIL tie_first: owner=%b, required 01", owner[0]);
    end
    cycle();
    b_valid[0] = 1'b0;
    b_tot[0] = 0;
    cycle();
    checks++;
    if (owner[0] !== 2'b00) begin
      errors++; $display("FAIL tie_idle: owner=%b, required 00", owner[0]);
    end
    a_tot[0] = 2;
    b_tot[0] = 1;
    drive(0, 1'b0, 1'b0);
    cycle();
    checks++;
    if (owner[0] !== 2'b10) begin
      errors++; $display("FAIL tie_second: owner=%b, required 10", owner[0]);
    end
    repeat (3) cycle();
    checks++;
    if (wn[0] != 3 || w_data[0][0] !== 16'h0100 || w_data[0][1] !== 16'h8100 || w_data[0][2] !== 16'h0101) begin
      errors++;
      $display("FAIL tie_writes: n=%0d d0=%h d1=%h d2=%h, required 3/0100/8100/0101",
               wn[0], w_data[0][0], w_data[0][1], w_data[0][2]);
    end
  endtask

  task automatic test_priority();
    int gaps;
    do_reset();
    setup_a(1, 7, 10'h040, 1, 16'h0C00, 100);
    setup_b(1, 20, 10'h300, 1, 16'h8D00, 100);
    repeat (14) cycle();
    checks++;
    if (src_str(1, 11) != "AABAABAABAB") begin
      errors++; $display("FAIL prio_order: got %s, required AABAABAABAB", src_str(1, 11));
    end
    gaps = 0;
    for (int c = 2; c <= 11; c++) if (!we_h[1][c]) gaps++;
    checks++;
    if (gaps != 0 || we_h[1][12] !== 1'b0 || we_h[1][13] !== 1'b1) begin
      errors++;
      $display("FAIL prio_bubble: gaps=%0d we12=%b we13=%b, required 0/0/1", gaps, we_h[1][12], we_h[1][13]);
    end
    checks++;
    if (own_h[1][12] !== 2'b10) begin
      errors++; $display("FAIL prio_handover: owner=%b, required 10", own_h[1][12]);
    end
    checks++;
    if (word_errs(1) != 0) begin
      errors++; $display("FAIL prio_words: bad=%0d, required 0", word_errs(1));
    end
  endtask

  task automatic test_single_burst();
    string exp;
    int gaps;
    do_reset();
    setup_a(2, 8, 10'h000, 1, 16'h1000, 100);
    setup_b(2, 8, 10'h3FF, -1, 16'h9000, 100);
    repeat (20) cycle();
    exp = "";
    for (int k = 0; k < 16; k++) exp = {exp, ((k % 2) != 0) ? "B" : "A"};
    checks++;
    if (wn[2] != 16 || src_str(2, 16) != exp) begin
      errors++; $display("FAIL alt_order: n=%0d got %s, required 16 %s", wn[2], src_str(2, 16), exp);
    end
    checks++;
    if (word_errs(2) != 0 || w_addr[2][1] !== 10'h3FF || w_addr[2][15] !== 10'h3F8) begin
      errors++;
      $display("FAIL alt_words: bad=%0d a1=%h a15=%h, required 0/3ff/3f8", word_errs(2), w_addr[2][1], w_addr[2][15]);
    end
    gaps = 0;
    for (int c = 2; c <= 17; c++) if (!we_h[2][c]) gaps++;
    checks++;
    if (gaps != 0) begin
      errors++; $display("FAIL alt_throughput: gaps=%0d, required 0", gaps);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      int i, lat_bad, run;
      i = r % N;
      do_reset();
      setup_a(i, int'($urandom_range(30, 5)), AW'($urandom), ($urandom_range(1) == 1) ? 1 : -1,
              {1'b0, 15'($urandom_range(32'h7F00))}, int'($urandom_range(100, 30)));
      setup_b(i, int'($urandom_range(30, 5)), AW'($urandom), ($urandom_range(1) == 1) ? 1 : -1,
              {1'b1, 15'($urandom_range(32'h7F00))}, int'($urandom_range(100, 30)));
      while ((a_sent[i] < a_tot[i] || b_sent[i] < b_tot[i]) && cn < 400) cycle();
      cycle();
      checks++;
      if (a_sent[i] != a_tot[i] || b_sent[i] != b_tot[i]) begin
        errors++;
        $display("FAIL rand%0d_timeout: sent=%0d/%0d, required %0d/%0d", r, a_sent[i], b_sent[i], a_tot[i], b_tot[i]);
      end
      checks++;
      if (wn[i] != a_tot[i] + b_tot[i]) begin
        errors++; $display("FAIL rand%0d_count: writes=%0d, required %0d", r, wn[i], a_tot[i] + b_tot[i]);
      end
      checks++;
      if (word_errs(i) != 0) begin
        errors++; $display("FAIL rand%0d_words: bad=%0d, required 0", r, word_errs(i));
      end
      lat_bad = 0;
      for (int c = 1; c <= cn; c++) if (we_h[i][c] != acc_h[i][c]) lat_bad++;
      checks++;
      if (lat_bad != 0) begin
        errors++; $display("FAIL rand%0d_latency: bad_cycles=%0d, required 0", r, lat_bad);
      end
      run = max_wait_run(i);
      checks++;
      if (run > mb_of[i]) begin
        errors++; $display("FAIL rand%0d_fairness: run=%0d, required <= %0d", r, run, mb_of[i]);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    mb_of[0] = 4;
    mb_of[1] = 2;
    mb_of[2] = 1;
    test_reset();
    test_a_only();
    test_round_robin_burst();
    test_tie();
    test_priority();
    test_single_burst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1);
  end

endmodule
